// File: rtl/trng_latch_pool.sv
// Latch-pool TRNG: excites a bank of SR latches, XORs their resolved outputs into raw bits,
// optionally von Neumann debiases them, packs words and guards the stream with a repetition test.
module trng_latch_pool #(
   parameter int unsigned NUM_LATCHES = 8,
   parameter int unsigned WORD_WIDTH  = 8,
   parameter int unsigned REP_LIMIT   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enabled,
   input  logic                  debias_en,
   input  logic                  test_mode,
   input  logic                  test_bit,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  health_fail
);

   localparam int unsigned CntWidth = $clog2(WORD_WIDTH + 1);
   localparam logic [CntWidth-1:0] LastBit = CntWidth'(WORD_WIDTH - 1);
   localparam logic [7:0] RepMax = 8'(REP_LIMIT);

   typedef enum logic [2:0] {StIdle, StExcite, StResolve, StCapture, StStall} state_e;

   state_e state_q, state_d;

   logic                   latch_s, latch_r;
   logic [NUM_LATCHES-1:0] latch_q;
   logic [NUM_LATCHES-1:0] ring_q, ring_d;

   logic [WORD_WIDTH-1:0]  acc_q, acc_d, acc_next;
   logic [CntWidth-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic [7:0]             rep_cnt_q, rep_cnt_d;
   logic                   last_raw_q, last_raw_d;
   logic                   health_fail_q, health_fail_d;
   logic                   pair_q, pair_d;
   logic                   first_q, first_d;
   logic                   debias_q;

   logic                   raw_bit;
   logic                   stall_req;
   logic                   capture_go;
   logic                   hf_set;
   logic                   accept;
   logic                   abit;

   always_comb begin
      latch_s = 1'b0;
      latch_r = 1'b1;
      unique case (state_q)
         StExcite: begin
            latch_s = 1'b1;
            latch_r = 1'b1;
         end
         StResolve, StCapture: begin
            latch_s = 1'b0;
            latch_r = 1'b0;
         end
         default: begin
            latch_s = 1'b0;
            latch_r = 1'b1;
         end
      endcase
   end

   // Johnson ring gives each behavioural cell a differing resolution seed after s=r=1 release.
   always_comb begin
      ring_d    = ring_q << 1;
      ring_d[0] = ~ring_q[NUM_LATCHES-1];
   end

   for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_latch
      logic q_q, armed_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q_q     <= 1'b0;
            armed_q <= 1'b0;
         end else begin
            case ({latch_s, latch_r})
               2'b01: begin
                  q_q     <= 1'b0;
                  armed_q <= 1'b0;
               end
               2'b10: begin
                  q_q     <= 1'b1;
                  armed_q <= 1'b0;
               end
               2'b11: begin
                  q_q     <= 1'b0;
                  armed_q <= 1'b1;
               end
               default: begin
                  if (armed_q) begin
                     q_q     <= ring_q[i];
                     armed_q <= 1'b0;
                  end
               end
            endcase
         end
      end

      assign latch_q[i] = q_q;
   end

   assign raw_bit = test_mode ? test_bit : ^latch_q;

   // A word-final capture with an unconsumed word parks in STALL instead of overwriting it.
   assign stall_req  = out_valid_q && !out_ready && (bit_cnt_q == LastBit);
   assign capture_go = (state_q == StCapture) && enabled && !health_fail_q && !stall_req;

   always_comb begin
      rep_cnt_d  = rep_cnt_q;
      last_raw_d = last_raw_q;
      hf_set     = 1'b0;
      if (capture_go) begin
         if ((rep_cnt_q != 8'd0) && (raw_bit == last_raw_q)) begin
            if (rep_cnt_q != RepMax) begin
               rep_cnt_d = rep_cnt_q + 8'd1;
            end
         end else begin
            rep_cnt_d = 8'd1;
         end
         last_raw_d = raw_bit;
         hf_set     = (rep_cnt_d == RepMax);
      end
      health_fail_d = health_fail_q | hf_set;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (enabled) state_d = StExcite;
         StExcite:  state_d = StResolve;
         StResolve: state_d = StCapture;
         StCapture: state_d = stall_req ? StStall : StExcite;
         StStall:   if (!out_valid_q || out_ready) state_d = StExcite;
         default:   state_d = StIdle;
      endcase
      if (!enabled || health_fail_q || hf_set) begin
         state_d = StIdle;
      end
   end

   always_comb begin
      pair_d  = pair_q;
      first_d = first_q;
      accept  = 1'b0;
      abit    = raw_bit;
      if (capture_go) begin
         if (!debias_en) begin
            accept = 1'b1;
         end else if (!pair_q) begin
            pair_d  = 1'b1;
            first_d = raw_bit;
         end else begin
            pair_d = 1'b0;
            accept = first_q ^ raw_bit;
            abit   = first_q;
         end
      end
      if ((state_d == StIdle) || (debias_en != debias_q)) begin
         pair_d = 1'b0;
      end
   end

   assign acc_next = (acc_q << 1) | WORD_WIDTH'(abit);

   always_comb begin
      acc_d       = acc_q;
      bit_cnt_d   = bit_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      if (accept) begin
         if (bit_cnt_q == LastBit) begin
            out_data_d  = acc_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            bit_cnt_d   = '0;
         end else begin
            acc_d     = acc_next;
            bit_cnt_d = bit_cnt_q + CntWidth'(1);
         end
      end
      if (state_d == StIdle) begin
         acc_d     = '0;
         bit_cnt_d = '0;
      end
      if (health_fail_q || hf_set) begin
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         ring_q        <= '0;
         acc_q         <= '0;
         bit_cnt_q     <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         rep_cnt_q     <= 8'd0;
         last_raw_q    <= 1'b0;
         health_fail_q <= 1'b0;
         pair_q        <= 1'b0;
         first_q       <= 1'b0;
         debias_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ring_q        <= ring_d;
         acc_q         <= acc_d;
         bit_cnt_q     <= bit_cnt_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         rep_cnt_q     <= rep_cnt_d;
         last_raw_q    <= last_raw_d;
         health_fail_q <= health_fail_d;
         pair_q        <= pair_d;
         first_q       <= first_d;
         debias_q      <= debias_en;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign health_fail = health_fail_q;

endmodule

// File: doc/trng_latch_pool.md
TRNG_LATCH_POOL -- requirements
Module: trng_latch_pool

Interface
REQ-001 Parameter NUM_LATCHES, default 8, SHALL set the number of sr_latch instances in the pool (legal range 1..64).
REQ-002 Parameter WORD_WIDTH, default 8, SHALL set the width of each delivered random word (legal range 1..32).
REQ-003 Parameter REP_LIMIT, default 16, SHALL set the repetition-count health threshold in raw bits (legal range 2..255).
REQ-004 clk  input  1  SHALL be the single clock; all flops SHALL be rising-edge triggered.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 enabled  input  1  SHALL run the harvest FSM while high.
REQ-007 debias_en  input  1  SHALL select von Neumann debiasing when high and raw pass-through when low.
REQ-008 test_mode  input  1  SHALL replace the latch-pool XOR with test_bit as the raw bit source when high.
REQ-009 test_bit  input  1  SHALL be the deterministic raw bit used in test_mode.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts out_data this cycle.
REQ-011 out_valid  output  1  SHALL indicate that out_data holds an unconsumed word.
REQ-012 out_data  output  WORD_WIDTH  SHALL carry the random word.
REQ-013 health_fail  output  1  SHALL be a sticky repetition-count failure flag.

Function
REQ-014 The latch drive SHALL be s=0, r=1 in IDLE, s=1, r=1 in EXCITE, and s=0, r=0 in RESOLVE and CAPTURE.
REQ-015 FSM states SHALL be IDLE, EXCITE, RESOLVE, CAPTURE, and STALL.
REQ-016 Transitions SHALL be IDLE->EXCITE on enabled, EXCITE->RESOLVE, RESOLVE->CAPTURE, and CAPTURE->EXCITE, or CAPTURE->STALL when out_valid=1 and the accumulator holds WORD_WIDTH-1 bits.
REQ-017 STALL->EXCITE SHALL occur on the cycle out_valid clears.
REQ-018 Any state SHALL go to IDLE when enabled=0; enabled=0 SHALL override all other transitions.
REQ-019 In CAPTURE, raw bit = test_mode ? test_bit : XOR of all NUM_LATCHES q outputs, so exactly one raw bit is produced per 3-cycle loop.
REQ-020 With debias_en=0, every raw bit SHALL be accepted.
REQ-021 With debias_en=1, raw bits SHALL be paired as first/second: 01 accepts bit 0, 10 accepts bit 1, and 00 or 11 is discarded.
REQ-022 The pair-phase flag SHALL clear on entry to IDLE and when debias_en changes.
REQ-023 Each accepted bit SHALL be shifted into the accumulator at bit 0, with older bits moving toward the MSB.
REQ-024 A bit counter of width clog2(WORD_WIDTH+1) SHALL count accepted bits.
REQ-025 On the accepting edge that completes WORD_WIDTH bits, the accumulator (including the new bit) SHALL load out_data, out_valid SHALL be set, and the counter SHALL be zeroed.
REQ-026 out_valid=1 with out_ready=1 SHALL clear out_valid on the next edge, and out_data SHALL hold its value.
REQ-027 A word completion on the same edge as consumption SHALL load the new word with out_valid remaining 1.
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 The repetition counter SHALL count consecutive identical raw bits before debiasing, saturating at REP_LIMIT.
REQ-030 On reaching REP_LIMIT, health_fail SHALL be set; health_fail SHALL clear only on rst.
REQ-031 While health_fail=1, the FSM SHALL stay in IDLE, out_valid SHALL be forced to 0, and any pending word SHALL be discarded.
REQ-032 Entering IDLE via enabled=0 SHALL clear the accumulator, the bit counter, and the pair phase; out_valid and out_data SHALL retain their values.

Reset
REQ-033 Asserting rst SHALL immediately force: FSM=IDLE, s=0, r=1, accumulator=0, counters=0, pair phase=0, out_valid=0, out_data=0, health_fail=0.
REQ-034 rst SHALL take effect mid-operation regardless of state.
REQ-035 After rst deasserts, the first EXCITE SHALL occur on the first rising edge with enabled=1.

Verification
REQ-036 Raw pass-through: test_mode=1, debias_en=0, test_bit=1, out_ready=0, enabled=1 -> out_valid rises at the end of the 8th CAPTURE (24 cycles after IDLE exit) with out_data=0xFF and health_fail=0.
REQ-037 Debias: test_mode=1, debias_en=1, raw stream 01,10,00,11,01,10,10,01,10,01 (and so on) -> the discarded 00/11 pairs do not count, and the first word = 0b01011010 shifted per REQ-023.
REQ-038 Backpressure: out_ready=0 while a second word completes -> FSM in STALL, out_data unchanged; raising out_ready for 1 cycle -> the next word follows 3 cycles later.
REQ-039 Health: test_bit held 0 for 16 raw bits -> health_fail=1 after the 16th CAPTURE, out_valid=0, and FSM IDLE until rst.
REQ-040 Async reset mid-word: assert rst during RESOLVE with 5 bits accumulated -> all outputs reach their reset values before the next edge, and a full new word requires 8 fresh bits.
REQ-041 Enable drop: deassert enabled with 3 bits accumulated and out_valid=1 -> out_valid/out_data held, accumulator cleared, and latches return to s=0, r=1.
